// File: rtl/lockstep_checker.sv
// -----------------------------------------------------------------------------
// lockstep_checker
//   Lockstep comparator between a pipelined CPU core (DUT) and its reference
//   model. Each side pushes committed-result records into its own alignment
//   FIFO, so the two sides may commit with different latencies. Matched pairs
//   are popped together and compared channel by channel under chan_mask. The
//   block counts matches and errors, flags overflow and timeout, and reports
//   a terminal PASS/FAIL verdict.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   chan_mask         1 = channel participates in the compare
//   dut_valid/data    DUT commit record (channel i = bits [i*WIDTH +: WIDTH])
//   dut_hlt           DUT halt reached writeback
//   model_valid/data  model commit record
//   model_hlt         model halt reached writeback
//   mismatch          one-cycle pulse: the last compared pair differed
//   mismatch_chan     per-channel differences of the last compare (held)
//   err_count         mismatching compares (saturating)
//   match_count       matching compares (saturating)
//   overflow          sticky: push into a full FIFO
//   timeout           sticky: TIMEOUT idle cycles without a compare
//   done              sticky: verdict reached
//   pass              valid when done = 1; 1 = PASS
// -----------------------------------------------------------------------------

// Alignment FIFO: DEPTH entries, pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module lockstep_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic [AW:0]   count;
  logic          push_ok;

  assign count   = wr_q - rd_q;
  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);
  // A push into a full FIFO is accepted only when a pop frees a slot the
  // same cycle; otherwise the record is dropped (overflow is flagged above).
  assign push_ok = push_i & (~full_o | pop_i);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // NOTE: storage has no reset; only the pointers define validity, so
  // clearing them empties the FIFO and keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)   rd_q <= rd_q + (AW+1)'(1);
    end
  end
endmodule

module lockstep_checker #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       chan_mask,
  input  logic                      dut_valid,
  input  logic [CHANNELS*WIDTH-1:0] dut_data,
  input  logic                      dut_hlt,
  input  logic                      model_valid,
  input  logic [CHANNELS*WIDTH-1:0] model_data,
  input  logic                      model_hlt,
  output logic                      mismatch,
  output logic [CHANNELS-1:0]       mismatch_chan,
  output logic [CNT_W-1:0]          err_count,
  output logic [CNT_W-1:0]          match_count,
  output logic                      overflow,
  output logic                      timeout,
  output logic                      done,
  output logic                      pass
);
  localparam int DW     = CHANNELS * WIDTH;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PASS, S_FAIL} state_t;

  state_t              state_q;
  logic                done_q, pass_q;
  logic                mismatch_q, mismatch_d;
  logic [CHANNELS-1:0] mchan_q, mchan_d;
  logic [CNT_W-1:0]    err_q, err_d, match_q, match_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                overflow_q, overflow_d, timeout_q, timeout_d;
  logic                dut_hlt_q, dut_hlt_d, model_hlt_q, model_hlt_d;

  logic [DW-1:0]       dut_head, model_head;
  logic                dut_empty, dut_full, model_empty, model_full;
  logic                active, pop;
  logic [CHANNELS-1:0] diff;
  logic                ovf_hit, timeout_hit, stop_hit, drain_skew;
  logic                fail_cond, pass_cond;

  lockstep_fifo #(.DW(DW), .DEPTH(DEPTH)) u_dut_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (dut_valid),
    .pop_i   (pop),
    .data_i  (dut_data),
    .data_o  (dut_head),
    .empty_o (dut_empty),
    .full_o  (dut_full)
  );

  lockstep_fifo #(.DW(DW), .DEPTH(DEPTH)) u_model_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (model_valid),
    .pop_i   (pop),
    .data_i  (model_data),
    .data_o  (model_head),
    .empty_o (model_empty),
    .full_o  (model_full)
  );

  // Compares (and everything that follows from them) stop once a verdict is in.
  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign pop    = active & ~dut_empty & ~model_empty;

  always_comb begin
    diff = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      diff[i] = (dut_head[i*WIDTH +: WIDTH] != model_head[i*WIDTH +: WIDTH]) & chan_mask[i];
    end
  end

  assign ovf_hit     = ((dut_valid & dut_full) | (model_valid & model_full)) & ~pop;
  assign timeout_hit = active & ~pop & (idle_q == IDLE_LAST);
  assign stop_hit    = (STOP_ON_ERR != 0) & pop & (|diff);
  // In DRAIN one side still holding records while the other is empty means
  // the two sides committed a different number of records.
  assign drain_skew  = (state_q == S_DRAIN) & (dut_empty != model_empty);
  assign fail_cond   = active & (stop_hit | ovf_hit | timeout_hit | drain_skew);
  assign pass_cond   = (state_q == S_DRAIN) & dut_empty & model_empty;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    mismatch_d  = 1'b0;
    mchan_d     = mchan_q;
    err_d       = err_q;
    match_d     = match_q;
    idle_d      = idle_q;
    overflow_d  = overflow_q | ovf_hit;
    timeout_d   = timeout_q | timeout_hit;
    dut_hlt_d   = dut_hlt_q | dut_hlt;
    model_hlt_d = model_hlt_q | model_hlt;

    if (pop) begin
      mismatch_d = |diff;
      mchan_d    = diff;
      idle_d     = '0;
      if (|diff) begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
      end else begin
        if (match_q != '1) match_d = match_q + CNT_W'(1);
      end
    end else if (active) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q  <= 1'b0;
      mchan_q     <= '0;
      err_q       <= '0;
      match_q     <= '0;
      idle_q      <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      dut_hlt_q   <= 1'b0;
      model_hlt_q <= 1'b0;
    end else begin
      mismatch_q  <= mismatch_d;
      mchan_q     <= mchan_d;
      err_q       <= err_d;
      match_q     <= match_d;
      idle_q      <= idle_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      dut_hlt_q   <= dut_hlt_d;
      model_hlt_q <= model_hlt_d;
    end
  end

  // Verdict FSM; FAIL takes priority over every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (fail_cond) begin
      state_q <= S_FAIL;
      done_q  <= 1'b1;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (dut_hlt_q && model_hlt_q) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pass_cond) begin
            state_q <= S_PASS;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign mismatch      = mismatch_q;
  assign mismatch_chan = mchan_q;
  assign err_count     = err_q;
  assign match_count   = match_q;
  assign overflow      = overflow_q;
  assign timeout       = timeout_q;
  assign done          = done_q;
  assign pass          = pass_q;
endmodule

// File: tb/tb_lockstep_checker.sv
// -----------------------------------------------------------------------------
// tb_lockstep_checker
//   Directed bench for lockstep_checker. Each test pushes its expected compare
//   results and expected verdict into queues; a monitor detects compares (a
//   step in match_count + err_count) and verdicts (rising done) and checks
//   them against the queue heads.
// -----------------------------------------------------------------------------
module tb_lockstep_checker;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 20;
  localparam int DW       = CHANNELS * WIDTH;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [CHANNELS-1:0] chan_mask = 4'b1111;
  logic                dut_valid = 1'b0, model_valid = 1'b0;
  logic                dut_hlt = 1'b0, model_hlt = 1'b0;
  logic [DW-1:0]       dut_data = '0, model_data = '0;
  logic                mismatch;
  logic [CHANNELS-1:0] mismatch_chan;
  logic [CNT_W-1:0]    err_count, match_count;
  logic                overflow, timeout, done, pass;

  lockstep_checker #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT), .STOP_ON_ERR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chan_mask(chan_mask),
    .dut_valid(dut_valid), .dut_data(dut_data), .dut_hlt(dut_hlt),
    .model_valid(model_valid), .model_data(model_data), .model_hlt(model_hlt),
    .mismatch(mismatch), .mismatch_chan(mismatch_chan),
    .err_count(err_count), .match_count(match_count),
    .overflow(overflow), .timeout(timeout), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic mis; logic [CHANNELS-1:0] chan; } cmp_t;
  typedef struct packed { logic pass; logic ovf; logic to; } verdict_t;

  cmp_t     exp_q[$];
  verdict_t vq[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not expected/expired", name);
  endtask

  function automatic logic [DW-1:0] mk_rec(input int k);
    logic [DW-1:0] r;
    for (int i = 0; i < CHANNELS; i++) r[i*WIDTH +: WIDTH] = WIDTH'(k * 16 + i + 256);
    return r;
  endfunction

  task automatic push_exp(input logic mis, input logic [CHANNELS-1:0] chan, input int n);
    cmp_t c;
    c.mis  = mis;
    c.chan = chan;
    for (int i = 0; i < n; i++) exp_q.push_back(c);
  endtask

  task automatic push_verdict(input logic p, input logic o, input logic t);
    verdict_t v;
    v.pass = p;
    v.ovf  = o;
    v.to   = t;
    vq.push_back(v);
  endtask

  // Drive one cycle of stimulus; inputs change 1 time unit after the edge.
  task automatic cyc(input logic dv, input logic [DW-1:0] dd, input logic mv,
                     input logic [DW-1:0] md, input logic dh, input logic mh);
    dut_valid   = dv;
    dut_data    = dd;
    model_valid = mv;
    model_data  = md;
    dut_hlt     = dh;
    model_hlt   = mh;
    @(posedge clk);
    #1;
    dut_valid   = 1'b0;
    model_valid = 1'b0;
    dut_hlt     = 1'b0;
    model_hlt   = 1'b0;
  endtask

  task automatic apply_reset(input bit check_zero);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    if (check_zero) begin
      check("rst_mismatch", int'(mismatch), 0);
      check("rst_mismatch_chan", int'(mismatch_chan), 0);
      check("rst_err_count", int'(err_count), 0);
      check("rst_match_count", int'(match_count), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_timeout", int'(timeout), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int max_cyc, output int cycles);
    cycles = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (done) begin
        cycles = n;
        break;
      end
    end
    if (cycles < 0) fail_now(name);
  endtask

  task automatic end_test(input string name);
    @(posedge clk);
    #1;
    check({name, "_cmp_queue_left"}, exp_q.size(), 0);
    check({name, "_verdict_queue_left"}, vq.size(), 0);
  endtask

  // Monitor: a compare shows up as a one-step rise of match+err; a verdict as
  // a rising done. Both are checked against the scoreboard queues.
  int prev_total = 0;
  bit prev_done  = 0;
  int sb_match   = 0;
  int sb_err     = 0;

  always @(negedge clk) begin
    int total;
    cmp_t c;
    verdict_t v;
    if (!rst_n) begin
      prev_total = 0;
      prev_done  = 0;
      sb_match   = 0;
      sb_err     = 0;
    end else begin
      total = int'(match_count) + int'(err_count);
      if (total != prev_total) begin
        check("compare_step", total, prev_total + 1);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_compare");
        end else begin
          c = exp_q.pop_front();
          check("cmp_mismatch", int'(mismatch), int'(c.mis));
          check("cmp_mismatch_chan", int'(mismatch_chan), int'(c.chan));
          if (c.mis) sb_err++;
          else sb_match++;
          check("cmp_match_count", int'(match_count), sb_match);
          check("cmp_err_count", int'(err_count), sb_err);
        end
      end
      prev_total = total;
      if (done && !prev_done) begin
        if (vq.size() == 0) begin
          fail_now("unexpected_verdict");
        end else begin
          v = vq.pop_front();
          check("verdict_pass", int'(pass), int'(v.pass));
          check("verdict_overflow", int'(overflow), int'(v.ovf));
          check("verdict_timeout", int'(timeout), int'(v.to));
        end
      end
      prev_done = done;
    end
  end

  task automatic run_mask_test(input logic [CHANNELS-1:0] mask, input bit expect_fail);
    logic [DW-1:0] md;
    int cycles;
    chan_mask = mask;
    if (expect_fail) begin
      push_exp(1'b0, '0, 2);
      push_exp(1'b1, 4'b0010, 1);
      push_verdict(1'b0, 1'b0, 1'b0);
    end else begin
      push_exp(1'b0, '0, 5);
      push_verdict(1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      md = mk_rec(k);
      if (k == 2) md = md ^ 64'h0000_0000_0040_0000;
      cyc(1'b1, mk_rec(k), 1'b1, md, 1'b0, 1'b0);
    end
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    wait_done(expect_fail ? "mis_done_wait" : "masked_done_wait", 50, cycles);
    if (expect_fail) begin
      check("mis_err_count", int'(err_count), 1);
      check("mis_match_count", int'(match_count), 2);
      check("mis_chan_held", int'(mismatch_chan), 4'b0010);
      check("mis_pass", int'(pass), 0);
    end else begin
      check("masked_match_count", int'(match_count), 5);
      check("masked_err_count", int'(err_count), 0);
      check("masked_pass", int'(pass), 1);
    end
    end_test(expect_fail ? "mis" : "masked");
    chan_mask = 4'b1111;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;

    // Reset state
    apply_reset(1'b1);

    // Lockstep match: 5 records, then both halts
    push_exp(1'b0, '0, 5);
    push_verdict(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, mk_rec(k), 1'b1, mk_rec(k), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    wait_done("lockstep_done_wait", 50, cycles);
    check("lockstep_done_within_3", int'(cycles >= 1 && cycles <= 3), 1);
    check("lockstep_match_count", int'(match_count), 5);
    check("lockstep_err_count", int'(err_count), 0);
    check("lockstep_pass", int'(pass), 1);
    end_test("lockstep");

    // Skew: model lags by 3 cycles, 6 records
    apply_reset(1'b0);
    push_exp(1'b0, '0, 6);
    push_verdict(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++)
      cyc(c < 6, mk_rec(c), (c >= 3) && (c < 9), mk_rec(c - 3), c == 6, c == 9);
    wait_done("skew_done_wait", 50, cycles);
    check("skew_overflow", int'(overflow), 0);
    check("skew_match_count", int'(match_count), 6);
    check("skew_pass", int'(pass), 1);
    end_test("skew");

    // Mismatch in ch1 of record 2, unmasked then masked
    apply_reset(1'b0);
    run_mask_test(4'b1111, 1'b1);
    apply_reset(1'b0);
    run_mask_test(4'b1101, 1'b0);

    // Overflow: 9 DUT pushes, model silent
    apply_reset(1'b0);
    push_verdict(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b1, mk_rec(k), 1'b0, '0, 1'b0, 1'b0);
    check("ovf_after_8", int'(overflow), 0);
    check("ovf_done_after_8", int'(done), 0);
    cyc(1'b1, mk_rec(8), 1'b0, '0, 1'b0, 1'b0);
    check("ovf_after_9", int'(overflow), 1);
    check("ovf_done", int'(done), 1);
    check("ovf_pass", int'(pass), 0);
    end_test("ovf");

    // Halt skew: DUT commits one extra record, both halt
    apply_reset(1'b0);
    push_exp(1'b0, '0, 5);
    push_verdict(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, mk_rec(k), 1'b1, mk_rec(k), 1'b0, 1'b0);
    cyc(1'b1, mk_rec(5), 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    wait_done("hskew_done_wait", 50, cycles);
    check("hskew_timeout", int'(timeout), 0);
    check("hskew_pass", int'(pass), 0);
    check("hskew_match_count", int'(match_count), 5);
    end_test("hskew");

    // Idle timeout: no traffic, no halts
    apply_reset(1'b0);
    push_verdict(1'b0, 1'b0, 1'b1);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("idle_timeout_before", int'(timeout), 0);
    check("idle_done_before", int'(done), 0);
    @(posedge clk);
    #1;
    check("idle_timeout_at", int'(timeout), 1);
    check("idle_done_at", int'(done), 1);
    check("idle_pass", int'(pass), 0);
    end_test("idle");

    // Reset mid-run with 4 DUT records queued
    apply_reset(1'b0);
    push_exp(1'b0, '0, 2);
    for (int k = 0; k < 2; k++) cyc(1'b1, mk_rec(k), 1'b1, mk_rec(k), 1'b0, 1'b0);
    for (int k = 2; k < 6; k++) cyc(1'b1, mk_rec(k), 1'b0, '0, 1'b0, 1'b0);
    check("midrst_match_before", int'(match_count), 2);
    apply_reset(1'b1);
    push_exp(1'b0, '0, 1);
    push_verdict(1'b1, 1'b0, 1'b0);
    cyc(1'b1, mk_rec(7), 1'b1, mk_rec(7), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    wait_done("midrst_done_wait", 50, cycles);
    check("midrst_match_count", int'(match_count), 1);
    check("midrst_err_count", int'(err_count), 0);
    check("midrst_pass", int'(pass), 1);
    end_test("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lockstep_checker.md
# lockstep_checker

Synthesizable lockstep comparator between the pipelined CPU core and its reference model, each instantiated side by side in the core bench. Each side pushes committed-result records into its own alignment FIFO, so differing pipeline latencies between the two do not matter. The block pops matched pairs and compares them channel by channel under a mask. It counts matches and errors, detects overflow, halt skew and timeout, and reports a final PASS/FAIL verdict.

## Interface
Parameters:
- WIDTH, 16, bits per channel (PC, ALU result, write data, ...)
- CHANNELS, 4, channels per commit record
- DEPTH, 8, entries per alignment FIFO (power of 2, ≥2)
- CNT_W, 16, width of the saturating counters
- TIMEOUT, 1000, idle cycles without a compare before timeout (≥1)
- STOP_ON_ERR, 1, 1 = first mismatch forces FAIL; 0 = count and continue

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- chan_mask  in  CHANNELS  1 = channel is compared
- dut_valid  in  1  DUT commit record present this cycle
- dut_data  in  CHANNELS*WIDTH  DUT record; channel i = bits [i*WIDTH +: WIDTH]
- dut_hlt  in  1  DUT halt reached writeback
- model_valid  in  1  model commit record present this cycle
- model_data  in  CHANNELS*WIDTH  model record
- model_hlt  in  1  model halt reached writeback
- mismatch  out  1  one-cycle pulse: the last compared pair differed
- mismatch_chan  out  CHANNELS  channels that differed on that compare; held until the next compare
- err_count  out  CNT_W  mismatching compares, saturating
- match_count  out  CNT_W  matching compares, saturating
- overflow  out  1  sticky: push into a full FIFO
- timeout  out  1  sticky: TIMEOUT exceeded
- done  out  1  sticky: verdict reached
- pass  out  1  valid when done=1; 1 = PASS

## Operation
- Reset: asynchronous active-low. All outputs go to 0, FIFOs are emptied, the idle counter is cleared, FSM enters RUN. A reset asserted mid-run discards all queued records immediately.
- FIFOs:
  - One FIFO per side, DEPTH entries each.
  - Push when the side's valid is high.
  - Pop both FIFOs in the same cycle when both are non-empty and the FSM is in RUN or DRAIN.
  - Push and pop in the same cycle on a full FIFO is legal: occupancy is unchanged.
  - Push into a full FIFO with no pop sets overflow; the record is dropped; FSM goes to FAIL.
- Compare: bitwise on the two FIFO heads. diff[i] = (dut head ch i ≠ model head ch i) & chan_mask[i]. A compare mismatches if diff ≠ 0.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Idle counter:
  - Clears on any compare.
  - Increments otherwise while in RUN or DRAIN.
  - Reaching TIMEOUT sets timeout and forces FAIL.
- FSM:
  - RUN: when both dut_hlt and model_hlt have been seen (each latched sticky; they may arrive in different cycles), go to DRAIN.
  - RUN/DRAIN: if exactly one halt has been latched and the other side's FIFO is empty while its own is non-empty for TIMEOUT cycles, this is halt skew and is covered by the timeout.
  - DRAIN: continue popping. When both FIFOs are empty, go to PASS. If exactly one FIFO is empty and the other non-empty, the record counts disagree: go to FAIL.
  - Any state: a mismatch with STOP_ON_ERR=1, overflow, or timeout sends the FSM to FAIL. Priority is FAIL > PASS.
  - PASS/FAIL are terminal until reset. done=1; pass=1 only in PASS. No pops or counter updates after done.
- A record pushed after both halts are latched is still compared.

## Timing
- Push to earliest pop: 1 cycle. A record written at edge N is at the FIFO head in cycle N+1.
- Pop to result: mismatch, mismatch_chan and the counters update on the edge that pops. They are visible the cycle after the pop cycle.
- Matched DUT/model records pushed in the same cycle: result 2 cycles after the valid cycle.
- Throughput: 1 compare per cycle.
- done/pass assert on the edge after the terminal condition is detected; latency 1 cycle.
- Halt latch: registered. DRAIN is entered 1 cycle after the second halt is seen.

## Test plan
- Lockstep match: 5 identical records on both sides in the same cycles, then both halts → match_count=5, err_count=0; done=1 and pass=1 at most 3 cycles after the halts.
- Skew: the model lags by 3 cycles, DEPTH=8, 6 records → no overflow, match_count=6, PASS.
- Mismatch with STOP_ON_ERR=1: record 2 differs in ch1 only, mask=4'b1111 → mismatch pulse, mismatch_chan=4'b0010, err_count=1, done=1, pass=0. Same test with mask=4'b1101 → match, eventual PASS.
- Overflow: DUT pushes 9 records while the model is silent, DEPTH=8 → overflow=1 on the 9th push, FAIL.
- Timeout/halt skew: DUT sends 1 extra record then halts, model halts, TIMEOUT=20 → after DRAIN the FIFO counts disagree, FAIL with timeout=0. With no halts and no traffic → timeout=1 after 20 idle cycles.
- Reset mid-run: assert rst_n=0 with 4 entries queued → all outputs 0 asynchronously; the FIFOs are empty after release.
